// File: rtl/tone_pkg.sv
// Shared constants and types for the tone synthesiser: sample rate,
// note half-period table (in sample ticks) and the envelope FSM states.
package tone_pkg;

    localparam int SAMPLE_HZ = 48000;

    // Index 0 is the rest tone and is never used for a playing note.
    // Entry i = round(SAMPLE_HZ / (2 * 261.63 * 2^((i-1)/12))).
    localparam logic [7:0] HALF_PER [16] = '{
        8'd0,  8'd92, 8'd87, 8'd82, 8'd77, 8'd73, 8'd69, 8'd65,
        8'd61, 8'd58, 8'd55, 8'd51, 8'd49, 8'd46, 8'd43, 8'd41
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } synth_state_t;

endpackage

// File: rtl/tone_divider.sv
// Square-wave phase divider: counts sample ticks and toggles polarity every
// half period. clear restarts the waveform at phase 0 with positive polarity.
module tone_divider
    import tone_pkg::*;
#(
    parameter int PHASE_W = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               tick,
    input  logic               clear,
    input  logic [PHASE_W-1:0] half_per,
    output logic               polarity
);

    logic [PHASE_W-1:0] phase_cnt_q;
    logic               polarity_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase_cnt_q <= '0;
            polarity_q  <= 1'b1;
        end else if (clear) begin
            phase_cnt_q <= '0;
            polarity_q  <= 1'b1;
        end else if (tick) begin
            // Exact-match wrap: a shorter half period after a retrigger keeps
            // counting through the natural counter rollover, so phase never jumps.
            if (phase_cnt_q == half_per - PHASE_W'(1)) begin
                phase_cnt_q <= '0;
                polarity_q  <= ~polarity_q;
            end else begin
                phase_cnt_q <= phase_cnt_q + PHASE_W'(1);
            end
        end
    end

    assign polarity = polarity_q;

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone synthesiser with attack/sustain/release envelope, driven
// by a held play level and a tone index, paced by the codec sample tick.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | silent, waiting for play with a non-rest tone
//   ATTACK  | amplitude ramps up by ENV_STEP per tick until AMP_MAX
//   SUSTAIN | amplitude held at AMP_MAX while play stays high
//   RELEASE | amplitude ramps down to 0; a new note retriggers ATTACK
module tone_synth
    import tone_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int AMP_MAX  = 8192,
    parameter int ENV_STEP = 64,
    parameter int PHASE_W  = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       play,
    input  logic [3:0]                 tone,
    input  logic                       sample_tick,
    output logic signed [SAMPLE_W-1:0] audio_sample,
    output logic                       sample_valid,
    output logic                       active
);

    localparam logic [SAMPLE_W-2:0] AMP_MAX_W  = AMP_MAX[SAMPLE_W-2:0];
    localparam logic [SAMPLE_W-2:0] ENV_STEP_W = ENV_STEP[SAMPLE_W-2:0];

    synth_state_t              state_q, state_d;
    logic [SAMPLE_W-2:0]       amp_q, amp_d;
    logic [SAMPLE_W-2:0]       amp_up, amp_dn;
    logic [3:0]                tone_q, tone_d;
    logic                      tick_q;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                      valid_q;
    logic                      active_q;
    logic                      start_note;
    logic                      div_clear;
    logic                      div_tick;
    logic                      polarity;

    tone_divider #(
        .PHASE_W (PHASE_W)
    ) u_divider (
        .clk      (clk),
        .resetN   (resetN),
        .tick     (div_tick),
        .clear    (div_clear),
        .half_per (PHASE_W'(HALF_PER[tone_q])),
        .polarity (polarity)
    );

    always_comb begin
        amp_up     = (amp_q >= AMP_MAX_W - ENV_STEP_W) ? AMP_MAX_W : amp_q + ENV_STEP_W;
        amp_dn     = (amp_q <= ENV_STEP_W) ? '0 : amp_q - ENV_STEP_W;
        start_note = play && (tone != 4'd0);
        div_clear  = (state_q == IDLE) && start_note;
        div_tick   = sample_tick && (state_q != IDLE);
    end

    // Envelope step follows the state in force when the tick arrives.
    always_comb begin
        amp_d = amp_q;
        case (state_q)
            ATTACK:  if (sample_tick) amp_d = amp_up;
            RELEASE: if (sample_tick) amp_d = amp_dn;
            default: amp_d = amp_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        case (state_q)
            IDLE: begin
                if (start_note) begin
                    state_d = ATTACK;
                    tone_d  = tone;
                end
            end
            ATTACK: begin
                if (!play) begin
                    state_d = RELEASE;
                end else if (amp_d == AMP_MAX_W) begin
                    state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                if (!play) state_d = RELEASE;
            end
            RELEASE: begin
                if (start_note) begin
                    state_d = ATTACK;
                    tone_d  = tone;
                end else if (amp_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The sample is formed the clock after the tick, from the already
    // updated amplitude and polarity.
    always_comb begin
        sample_d = polarity ? $signed({1'b0, amp_q}) : -$signed({1'b0, amp_q});
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            amp_q    <= '0;
            tone_q   <= 4'd0;
            tick_q   <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            amp_q    <= amp_d;
            tone_q   <= tone_d;
            tick_q   <= sample_tick;
            valid_q  <= tick_q;
            if (tick_q) sample_q <= sample_d;
            active_q <= (state_d != IDLE);
        end
    end

    assign audio_sample = sample_q;
    assign sample_valid = valid_q;
    assign active       = active_q;

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
Sound-side consumer of the game's `play`/`tone` request interface. It converts a held `play` level and a 4-bit tone index into a signed square-wave PCM stream with an attack/sustain/release envelope. Output samples are paced by a `sample_tick` strobe from the audio codec interface. It sits between the game-event sound FSMs and the codec serializer.

Parameters:
SAMPLE_W, 16, audio sample width (signed two's complement)
AMP_MAX, 8192, sustain amplitude (must be < 2^(SAMPLE_W-1) and a multiple of ENV_STEP)
ENV_STEP, 64, amplitude change per sample_tick during attack/release
PHASE_W, 8, width of the half-period counter

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
play  in  1  level request: sound while high
tone  in  4  tone index; 0 = rest, 1..15 = notes
sample_tick  in  1  one-clk strobe at SAMPLE_HZ (48 kHz)
audio_sample  out  SAMPLE_W  signed PCM sample to codec
sample_valid  out  1  one-clk strobe: audio_sample updated
active  out  1  high whenever state != IDLE

Behaviour:
- Reset: clk and resetN (asynchronous, active-low). Reset forces state=IDLE, amp=0, phase_cnt=0, polarity=+, tone_q=0, audio_sample=0, sample_valid=0, active=0. A reset mid-note silences the output immediately; there is no release.
- Half-period lookup: HALF_PER[tone_q] = round(48000 / (2 * 261.63 * 2^((i-1)/12))) for i = 1..15. Examples: 1→92, 3→82, 13→46. HALF_PER[0] is unused.
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE.
  - IDLE: when play=1 and tone!=0, latch tone_q=tone, clear phase_cnt, set polarity=+, go to ATTACK. play=1 with tone=0 stays in IDLE. A sample_tick in the transition cycle is ignored.
  - ATTACK: on each sample_tick, amp = min(amp+ENV_STEP, AMP_MAX). When amp reaches AMP_MAX, go to SUSTAIN. If play=0, go to RELEASE (checked every clk).
  - SUSTAIN: amp is held. If play=0, go to RELEASE.
  - RELEASE: on each sample_tick, amp = max(amp-ENV_STEP, 0). When amp reaches 0, go to IDLE.
    - play=1 with tone!=0 retriggers: go to ATTACK, relatch tone_q, keep amp and phase (no click).
    - play=1 with tone=0 continues the release.
- tone changes while in ATTACK or SUSTAIN are ignored; tone is sampled only on entry to ATTACK.
- Phase counter: on each sample_tick while not in IDLE:
  - if phase_cnt == HALF_PER[tone_q]-1, then phase_cnt=0 and polarity toggles;
  - otherwise phase_cnt increments.
- Output timing: one clk after each sample_tick:
  - audio_sample = polarity ? +amp : -amp, using the post-update amp;
  - sample_valid pulses for 1 clk.
- In IDLE, sample_valid still pulses on each tick and audio_sample=0.
- Width rules: amp is SAMPLE_W-1 bits unsigned; negation is done at SAMPLE_W bits; no overflow, because AMP_MAX < 2^(SAMPLE_W-1).
- Simultaneous events:
  - play falling in the same clk as the ATTACK saturation goes to RELEASE (play wins).
  - sample_tick in the same clk as a state change uses the old state's envelope rule.
- active is registered and mirrors state != IDLE.

Decomposition:
- Package tone_pkg holds:
  - SAMPLE_HZ;
  - the 16-entry HALF_PER constant array;
  - the synth_state_t enum {IDLE, ATTACK, SUSTAIN, RELEASE}.
- Sub-module tone_divider holds the phase counter and polarity. Its inputs are clk, resetN, tick, clear, half_per; its output is polarity.
- The FSM, envelope and output register stay in tone_synth.

Test Plan:
- Reset: hold resetN=0 while applying ticks → audio_sample=0, active=0, sample_valid=0; after release, IDLE ticks give sample_valid pulses with value 0.
- Attack: play=1, tone=3 → 128 ticks later amp=8192 and state=SUSTAIN; polarity flips every 82 ticks; samples alternate between +8192 and -8192.
- Release: drop play in SUSTAIN → magnitude falls by 64 per tick; after 128 ticks active=0 and audio_sample=0.
- Retrigger: play low after 64 attack ticks (amp=4096); raise play 10 ticks later with tone=13 → re-enters ATTACK from amp=3456, half-period is 46, phase is unbroken.
- Rest and tone change: play=1, tone=0 → stays IDLE. tone changed from 1 to 5 during SUSTAIN → half-period stays 92.
- Async reset mid-SUSTAIN → outputs go to 0 immediately, without waiting for a clk edge.
